// File: rtl/rsa_driver.sv
// rsa_driver: bus initiator that runs one RSA exponentiation on the MMIO RSA
// peripheral. It loads the operands, starts the engine, polls RESULT_VALID,
// reads the 64-bit result back and stops the engine.
// Optional feature macro: RSA_DRIVER_TIMEOUT_EN (polling timeout and error path).
module rsa_driver #(
  parameter int unsigned POLL_INTERVAL  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] message,
  input  logic [63:0] modulus,
  input  logic [63:0] exponent,
  input  logic [63:0] residue,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] result,
  output logic        rsa_enable,
  output logic        bus_write_en,
  output logic        bus_read_en,
  output logic [7:0]  bus_addr,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data
);

  localparam int unsigned AW     = 8;
  localparam int unsigned DW     = 32;
  localparam int unsigned OW     = 64;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned TMO_W  = 20;
  localparam int unsigned WAIT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam bit          NO_WAIT = (POLL_INTERVAL == 0);

  localparam logic [AW-1:0] ADDR_BIT_SWITCH   = 8'h08;
  localparam logic [AW-1:0] ADDR_MESSAGE      = 8'h0C;
  localparam logic [AW-1:0] ADDR_MODULUS      = 8'h10;
  localparam logic [AW-1:0] ADDR_EXPONENT     = 8'h14;
  localparam logic [AW-1:0] ADDR_RESIDUE      = 8'h18;
  localparam logic [AW-1:0] ADDR_RSA_ENCRYPT  = 8'h1C;
  localparam logic [AW-1:0] ADDR_RESULT       = 8'h20;
  localparam logic [AW-1:0] ADDR_RESULT_VALID = 8'h24;

  localparam logic [STEP_W-1:0] LAST_STEP = 4'd10;
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(POLL_INTERVAL - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WRITE, S_POLL_RD, S_POLL_WAIT, S_SEL_LO,
    S_RD_LO, S_SEL_HI, S_RD_HI, S_STOP, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [OW-1:0]       msg_q, mod_q, exp_q, res_q;
  logic [OW-1:0]       result_d;
  logic                start_acc_c;
  logic                tmo_hit_c;
  logic                tmo_fire_c;
  logic                busy_d, done_d;
  logic                en_d, we_d, re_d;
  logic [AW-1:0]       addr_d;
  logic [DW-1:0]       wdata_d;

  assign start_acc_c = (state_q == S_IDLE) && start;

  // Next state, result capture and the bus cycle presented in the next state
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    wait_d     = wait_q;
    result_d   = result;
    tmo_fire_c = 1'b0;
    en_d       = 1'b0;
    we_d       = 1'b0;
    re_d       = 1'b0;
    addr_d     = '0;
    wdata_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          step_d  = '0;
        end
      end
      S_WRITE: begin
        if (step_q == LAST_STEP) state_d = S_POLL_RD;
        else                     step_d  = STEP_W'(step_q + 1'b1);
      end
      S_POLL_RD: begin
        if (bus_read_data[0]) begin
          state_d = S_SEL_LO;
        end else if (tmo_hit_c) begin
          state_d    = S_STOP;
          tmo_fire_c = 1'b1;
        end else if (NO_WAIT) begin
          state_d = S_POLL_RD;
        end else begin
          state_d = S_POLL_WAIT;
          wait_d  = '0;
        end
      end
      S_POLL_WAIT: begin
        if (tmo_hit_c) begin
          state_d    = S_STOP;
          tmo_fire_c = 1'b1;
        end else if (wait_q == LAST_WAIT) begin
          state_d = S_POLL_RD;
        end else begin
          wait_d = WAIT_W'(wait_q + 1'b1);
        end
      end
      S_SEL_LO: state_d = S_RD_LO;
      S_RD_LO: begin
        result_d[31:0] = bus_read_data;
        state_d        = S_SEL_HI;
      end
      S_SEL_HI: state_d = S_RD_HI;
      S_RD_HI: begin
        result_d[63:32] = bus_read_data;
        state_d         = S_STOP;
      end
      S_STOP:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (tmo_fire_c) result_d = '0;

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);

    case (state_d)
      S_WRITE: begin
        en_d = 1'b1;
        we_d = 1'b1;
        case (step_d)
          4'd0:    begin addr_d = ADDR_BIT_SWITCH; wdata_d = 32'd0;          end
          4'd1:    begin addr_d = ADDR_MESSAGE;    wdata_d = msg_q[31:0];    end
          4'd2:    begin addr_d = ADDR_MODULUS;    wdata_d = mod_q[31:0];    end
          4'd3:    begin addr_d = ADDR_EXPONENT;   wdata_d = exp_q[31:0];    end
          4'd4:    begin addr_d = ADDR_RESIDUE;    wdata_d = res_q[31:0];    end
          4'd5:    begin addr_d = ADDR_BIT_SWITCH; wdata_d = 32'd1;          end
          4'd6:    begin addr_d = ADDR_MESSAGE;    wdata_d = msg_q[63:32];   end
          4'd7:    begin addr_d = ADDR_MODULUS;    wdata_d = mod_q[63:32];   end
          4'd8:    begin addr_d = ADDR_EXPONENT;   wdata_d = exp_q[63:32];   end
          4'd9:    begin addr_d = ADDR_RESIDUE;    wdata_d = res_q[63:32];   end
          default: begin addr_d = ADDR_RSA_ENCRYPT; wdata_d = 32'd1;         end
        endcase
      end
      S_POLL_RD: begin en_d = 1'b1; re_d = 1'b1; addr_d = ADDR_RESULT_VALID; end
      S_SEL_LO:  begin en_d = 1'b1; we_d = 1'b1; addr_d = ADDR_BIT_SWITCH; wdata_d = 32'd0; end
      S_RD_LO:   begin en_d = 1'b1; re_d = 1'b1; addr_d = ADDR_RESULT; end
      S_SEL_HI:  begin en_d = 1'b1; we_d = 1'b1; addr_d = ADDR_BIT_SWITCH; wdata_d = 32'd1; end
      S_RD_HI:   begin en_d = 1'b1; re_d = 1'b1; addr_d = ADDR_RESULT; end
      S_STOP:    begin en_d = 1'b1; we_d = 1'b1; addr_d = ADDR_RSA_ENCRYPT; wdata_d = 32'd0; end
      default:   ;
    endcase
  end

  // State register, step/wait counters and registered outputs
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      step_q         <= '0;
      wait_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      result         <= '0;
      rsa_enable     <= 1'b0;
      bus_write_en   <= 1'b0;
      bus_read_en    <= 1'b0;
      bus_addr       <= '0;
      bus_write_data <= '0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      wait_q         <= wait_d;
      busy           <= busy_d;
      done           <= done_d;
      result         <= result_d;
      rsa_enable     <= en_d;
      bus_write_en   <= we_d;
      bus_read_en    <= re_d;
      bus_addr       <= addr_d;
      bus_write_data <= wdata_d;
    end
  end

  // Operand capture on an accepted start; inputs are free to change afterwards
  always_ff @(posedge pclk) begin
    if (start_acc_c) begin
      msg_q <= message;
      mod_q <= modulus;
      exp_q <= exponent;
      res_q <= residue;
    end
  end

`ifdef RSA_DRIVER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  // Hit when the current cycle is the last one allowed in the polling phase
  assign tmo_hit_c = (21'(tmo_q) + 21'd1) >= 21'(TIMEOUT_CYCLES);
  assign error     = err_q;

  // Polling-phase cycle counter, cleared while the operands are being written
  always_ff @(posedge pclk) begin
    if (reset)                                                  tmo_q <= '0;
    else if (state_q == S_WRITE)                                tmo_q <= '0;
    else if ((state_q == S_POLL_RD) || (state_q == S_POLL_WAIT)) tmo_q <= TMO_W'(tmo_q + 1'b1);
  end

  // Timeout flag, reported alongside done and cleared by the next run
  always_ff @(posedge pclk) begin
    if (reset)            err_q <= 1'b0;
    else if (start_acc_c) err_q <= 1'b0;
    else if (tmo_fire_c)  err_q <= 1'b1;
  end
`else
  assign tmo_hit_c = 1'b0;
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_driver.sv
// tb_rsa_driver: scoreboard bench for rsa_driver with a behavioural RSA
// peripheral responder. Two instances: POLL_INTERVAL=4/TIMEOUT=50 and POLL_INTERVAL=0.
module tb_rsa_driver;

  localparam logic [63:0] RES = 64'h0123456789ABCDEF;

  typedef struct {
    int          cyc;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    int          cyc;
    logic [63:0] res;
    logic        err;
  } dn_t;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  logic        reset;
  logic        start_a, start_b;
  logic [63:0] message, modulus, exponent, residue;

  logic        busy_a, done_a, error_a, en_a, we_a, re_a;
  logic [63:0] result_a;
  logic [7:0]  addr_a;
  logic [31:0] wd_a, rd_a;
  logic        busy_b, done_b, error_b, en_b, we_b, re_b;
  logic [63:0] result_b;
  logic [7:0]  addr_b;
  logic [31:0] wd_b, rd_b;

  int errors = 0;
  int checks = 0;
  int base   = 0;
  int vpoll_a = 0, vpoll_b = 0;
  int pc_a = 0, pc_b = 0;
  logic bsw_a, bsw_b;

  txn_t q_a[$];
  txn_t q_b[$];
  dn_t  d_a[$];
  dn_t  d_b[$];
  txn_t ta, tb;
  dn_t  da, db;

  rsa_driver #(.POLL_INTERVAL(4), .TIMEOUT_CYCLES(50)) dut_a (
    .pclk(pclk), .reset(reset), .start(start_a),
    .message(message), .modulus(modulus), .exponent(exponent), .residue(residue),
    .busy(busy_a), .done(done_a), .error(error_a), .result(result_a),
    .rsa_enable(en_a), .bus_write_en(we_a), .bus_read_en(re_a),
    .bus_addr(addr_a), .bus_write_data(wd_a), .bus_read_data(rd_a)
  );

  rsa_driver #(.POLL_INTERVAL(0)) dut_b (
    .pclk(pclk), .reset(reset), .start(start_b),
    .message(message), .modulus(modulus), .exponent(exponent), .residue(residue),
    .busy(busy_b), .done(done_b), .error(error_b), .result(result_b),
    .rsa_enable(en_b), .bus_write_en(we_b), .bus_read_en(re_b),
    .bus_addr(addr_b), .bus_write_data(wd_b), .bus_read_data(rd_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Peripheral responder: RESULT_VALID rises on the vpoll-th poll after RSA_ENCRYPT
  always_comb begin
    rd_a = 32'd0;
    if (re_a && addr_a == 8'h24) rd_a = {31'd0, (vpoll_a != 0) && (pc_a + 1 >= vpoll_a)};
    else if (re_a && addr_a == 8'h20) rd_a = bsw_a ? RES[63:32] : RES[31:0];
  end
  always_comb begin
    rd_b = 32'd0;
    if (re_b && addr_b == 8'h24) rd_b = {31'd0, (vpoll_b != 0) && (pc_b + 1 >= vpoll_b)};
    else if (re_b && addr_b == 8'h20) rd_b = bsw_b ? RES[63:32] : RES[31:0];
  end

  always @(posedge pclk) begin
    if (reset) begin
      bsw_a <= 1'b0; pc_a <= 0;
    end else begin
      if (we_a && addr_a == 8'h08) bsw_a <= wd_a[0];
      if (we_a && addr_a == 8'h1C) pc_a <= 0;
      else if (re_a && addr_a == 8'h24) pc_a <= pc_a + 1;
    end
  end
  always @(posedge pclk) begin
    if (reset) begin
      bsw_b <= 1'b0; pc_b <= 0;
    end else begin
      if (we_b && addr_b == 8'h08) bsw_b <= wd_b[0];
      if (we_b && addr_b == 8'h1C) pc_b <= 0;
      else if (re_b && addr_b == 8'h24) pc_b <= pc_b + 1;
    end
  end

  // Bus and completion monitors: pop expected items as the DUT produces them
  always @(negedge pclk) begin
    if (en_a) begin
      chk("a_bus_expected", 64'(q_a.size() > 0), 64'd1);
      if (q_a.size() > 0) begin
        ta = q_a.pop_front();
        chk("a_bus_cycle", 64'(cyc), 64'(ta.cyc));
        chk("a_bus_we", 64'(we_a), 64'(ta.we));
        chk("a_bus_re", 64'(re_a), 64'(!ta.we));
        chk("a_bus_addr", 64'(addr_a), 64'(ta.addr));
        if (ta.we) chk("a_bus_wdata", 64'(wd_a), 64'(ta.data));
      end
    end else begin
      chk("a_bus_idle", 64'({we_a, re_a, addr_a, wd_a}), 64'd0);
    end
    if (done_a) begin
      chk("a_done_expected", 64'(d_a.size() > 0), 64'd1);
      if (d_a.size() > 0) begin
        da = d_a.pop_front();
        chk("a_done_cycle", 64'(cyc), 64'(da.cyc));
        chk("a_done_result", result_a, da.res);
        chk("a_done_error", 64'(error_a), 64'(da.err));
        chk("a_done_busy", 64'(busy_a), 64'd0);
      end
    end
  end

  always @(negedge pclk) begin
    if (en_b) begin
      chk("b_bus_expected", 64'(q_b.size() > 0), 64'd1);
      if (q_b.size() > 0) begin
        tb = q_b.pop_front();
        chk("b_bus_cycle", 64'(cyc), 64'(tb.cyc));
        chk("b_bus_we", 64'(we_b), 64'(tb.we));
        chk("b_bus_re", 64'(re_b), 64'(!tb.we));
        chk("b_bus_addr", 64'(addr_b), 64'(tb.addr));
        if (tb.we) chk("b_bus_wdata", 64'(wd_b), 64'(tb.data));
      end
    end else begin
      chk("b_bus_idle", 64'({we_b, re_b, addr_b, wd_b}), 64'd0);
    end
    if (done_b) begin
      chk("b_done_expected", 64'(d_b.size() > 0), 64'd1);
      if (d_b.size() > 0) begin
        db = d_b.pop_front();
        chk("b_done_cycle", 64'(cyc), 64'(db.cyc));
        chk("b_done_result", result_b, db.res);
        chk("b_done_error", 64'(error_b), 64'(db.err));
        chk("b_done_busy", 64'(busy_b), 64'd0);
      end
    end
  end

  task automatic push_txn(input bit b, input int k, input logic we, input logic [7:0] addr,
                          input logic [31:0] data);
    txn_t t;
    t.cyc = base + k; t.we = we; t.addr = addr; t.data = data;
    if (b) q_b.push_back(t);
    else   q_a.push_back(t);
  endtask

  task automatic push_done(input bit b, input int k, input logic [63:0] res, input logic err);
    dn_t d;
    d.cyc = base + k; d.res = res; d.err = err;
    if (b) d_b.push_back(d);
    else   d_a.push_back(d);
  endtask

  // Expected operand-load writes in cycles 1..upto
  task automatic push_writes(input bit b, input int upto, input logic [63:0] m,
                             input logic [63:0] mo, input logic [63:0] e, input logic [63:0] r);
    logic [7:0]  wa [11];
    logic [31:0] wd [11];
    wa = '{8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
    wd = '{32'd0, m[31:0], mo[31:0], e[31:0], r[31:0], 32'd1,
           m[63:32], mo[63:32], e[63:32], r[63:32], 32'd1};
    for (int i = 0; i < 11; i++)
      if (i + 1 <= upto) push_txn(b, i + 1, 1'b1, wa[i], wd[i]);
  endtask

  // Full successful run: valid on poll number nvalid
  task automatic push_run(input bit b, input logic [63:0] m, input logic [63:0] mo,
                          input logic [63:0] e, input logic [63:0] r,
                          input int interval, input int nvalid);
    int p;
    push_writes(b, 11, m, mo, e, r);
    p = 12;
    for (int i = 1; i <= nvalid; i++) begin
      push_txn(b, p, 1'b0, 8'h24, 32'd0);
      if (i < nvalid) p = p + interval + 1;
    end
    push_txn(b, p + 1, 1'b1, 8'h08, 32'd0);
    push_txn(b, p + 2, 1'b0, 8'h20, 32'd0);
    push_txn(b, p + 3, 1'b1, 8'h08, 32'd1);
    push_txn(b, p + 4, 1'b0, 8'h20, 32'd0);
    push_txn(b, p + 5, 1'b1, 8'h1C, 32'd0);
    push_done(b, p + 6, RES, 1'b0);
  endtask

  task automatic go_to(input int k);
    while (cyc < base + k) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Pulse start for one cycle; on return the bench is in cycle 1
  task automatic start_run(input bit b, input logic [63:0] m, input logic [63:0] mo,
                           input logic [63:0] e, input logic [63:0] r);
    @(posedge pclk);
    #1;
    message = m; modulus = mo; exponent = e; residue = r;
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    base = cyc;
    @(posedge pclk);
    #1;
    start_a = 1'b0; start_b = 1'b0;
    message  = {$urandom, $urandom};
    modulus  = {$urandom, $urandom};
    exponent = {$urandom, $urandom};
    residue  = {$urandom, $urandom};
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    message = '0; modulus = '0; exponent = '0; residue = '0;
    repeat (3) @(posedge pclk);
    #1;
    chk("a_reset_outs", 64'({busy_a, done_a, error_a, en_a, we_a, re_a, addr_a, wd_a}), 64'd0);
    chk("a_reset_result", result_a, 64'd0);
    chk("b_reset_outs", 64'({busy_b, done_b, error_b, en_b, we_b, re_b, addr_b, wd_b}), 64'd0);
    chk("b_reset_result", result_b, 64'd0);
    reset = 1'b0;

    // Normal run, poll interval 4, valid on the third poll
    vpoll_a = 3;
    start_run(1'b0, 64'h2, 64'hC5, 64'h3, 64'h7C);
    push_run(1'b0, 64'h2, 64'hC5, 64'h3, 64'h7C, 4, 3);
    chk("a_busy_cycle1", 64'(busy_a), 64'd1);
    go_to(28);
    chk("a_done_at_28", 64'(done_a), 64'd1);
    go_to(40);
    chk("a_q_empty_run1", 64'(q_a.size() + d_a.size()), 64'd0);
    chk("a_result_held", result_a, RES);

    // start while busy and in the done cycle must be ignored
    start_run(1'b0, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3211,
              64'h0000_0001_0000_0003, 64'h1111_2222_3333_4444);
    push_run(1'b0, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3211,
             64'h0000_0001_0000_0003, 64'h1111_2222_3333_4444, 4, 3);
    go_to(5);
    start_a = 1'b1;
    go_to(6);
    start_a = 1'b0;
    go_to(28);
    start_a = 1'b1;
    go_to(29);
    start_a = 1'b0;
    go_to(50);
    chk("a_q_empty_ignored", 64'(q_a.size() + d_a.size()), 64'd0);
    chk("a_idle_after_ignored", 64'(busy_a), 64'd0);

    // Reset during cycle 7 of the operand load, then a clean run
    start_run(1'b0, 64'hAAAA_5555_0F0F_F0F0, 64'hFFFF_0000_FFFF_0001,
              64'h0000_0000_0001_0001, 64'h0123_0000_0000_4567);
    push_writes(1'b0, 7, 64'hAAAA_5555_0F0F_F0F0, 64'hFFFF_0000_FFFF_0001,
                64'h0000_0000_0001_0001, 64'h0123_0000_0000_4567);
    go_to(7);
    reset = 1'b1;
    go_to(8);
    reset = 1'b0;
    chk("a_midrst_outs", 64'({busy_a, done_a, error_a, en_a, we_a, re_a, addr_a, wd_a}), 64'd0);
    chk("a_midrst_result", result_a, 64'd0);
    chk("a_midrst_q", 64'(q_a.size()), 64'd0);
    go_to(12);
    start_run(1'b0, 64'h5, 64'hD3, 64'h7, 64'h9A);
    push_run(1'b0, 64'h5, 64'hD3, 64'h7, 64'h9A, 4, 3);
    go_to(40);
    chk("a_q_empty_after_rst", 64'(q_a.size() + d_a.size()), 64'd0);

    // Poll interval 0: valid on first poll gives done 18 cycles after start
    vpoll_b = 1;
    start_run(1'b1, 64'h2, 64'hC5, 64'h3, 64'h7C);
    push_run(1'b1, 64'h2, 64'hC5, 64'h3, 64'h7C, 0, 1);
    go_to(18);
    chk("b_done_at_18", 64'(done_b), 64'd1);
    go_to(25);
    chk("b_q_empty_fast", 64'(q_b.size() + d_b.size()), 64'd0);

    // Poll interval 0: back-to-back polls, valid on the third
    vpoll_b = 3;
    start_run(1'b1, 64'h9, 64'hE1, 64'h11, 64'h33);
    push_run(1'b1, 64'h9, 64'hE1, 64'h11, 64'h33, 0, 3);
    go_to(30);
    chk("b_q_empty_b2b", 64'(q_b.size() + d_b.size()), 64'd0);

    // Responder never valid
    vpoll_a = 0;
    start_run(1'b0, 64'h2, 64'hC5, 64'h3, 64'h7C);
    push_writes(1'b0, 11, 64'h2, 64'hC5, 64'h3, 64'h7C);
`ifdef RSA_DRIVER_TIMEOUT_EN
    for (int k = 0; k < 10; k++) push_txn(1'b0, 12 + 5 * k, 1'b0, 8'h24, 32'd0);
    push_txn(1'b0, 62, 1'b1, 8'h1C, 32'd0);
    push_done(1'b0, 63, 64'd0, 1'b1);
    go_to(63);
    chk("a_timeout_done", 64'(done_a), 64'd1);
    chk("a_timeout_error", 64'(error_a), 64'd1);
    go_to(70);
    chk("a_q_empty_timeout", 64'(q_a.size() + d_a.size()), 64'd0);
`else
    for (int k = 0; 12 + 5 * k <= 1100; k++) push_txn(1'b0, 12 + 5 * k, 1'b0, 8'h24, 32'd0);
    go_to(1050);
    chk("a_still_busy", 64'(busy_a), 64'd1);
    chk("a_no_error", 64'(error_a), 64'd0);
    go_to(1100);
    reset = 1'b1;
    go_to(1101);
    reset = 1'b0;
    chk("a_poll_rst_outs", 64'({busy_a, done_a, error_a, en_a, we_a, re_a, addr_a, wd_a}), 64'd0);
    chk("a_q_empty_notimeout", 64'(q_a.size() + d_a.size()), 64'd0);
`endif

    repeat (5) @(posedge pclk);
    #1;
    chk("all_q_empty", 64'(q_a.size() + d_a.size() + q_b.size() + d_b.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
